penta_serial_sub: RTL and testbench

PENTA_SERIAL_SUB -- requirements
Module: penta_serial_sub

---
 rtl/penta_serial_sub.sv | 146 ++++++++++++++
 tb/tb_penta_serial_sub.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/penta_serial_sub.sv
// Serial base-5 subtractor, LSD first, one digit pair per transfer.
// Single output register with valid/ready; sticky frame error and overflow.
module penta_serial_sub #(
  parameter int MAX_DIGITS = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] a_dig,
  input  logic [2:0] b_dig,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] diff_dig,
  output logic       out_last,
  output logic       out_bout,
  output logic       out_err
);

  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam logic [CW-1:0] MAXC = CW'(MAX_DIGITS);

  typedef enum logic {
    IDLE,
    MID
  } state_t;

  state_t          r_state;
  state_t          w_state_nx;
  logic            r_borrow;
  logic [CW-1:0]   r_cnt;
  logic            r_err;

  logic            r_out_valid;
  logic [2:0]      r_diff;
  logic            r_last;
  logic            r_bout;
  logic            r_oerr;

  logic            w_fire;
  logic            w_bad;
  logic            w_bin;
  logic [CW-1:0]   w_cnt_cur;
  logic [CW-1:0]   w_cnt_nx;
  logic            w_max;
  logic            w_final;
  logic            w_ovf;
  logic            w_err;
  logic signed [4:0] w_t;
  logic [4:0]      w_tp5;
  logic [2:0]      w_diff;
  logic            w_nb;

  assign in_ready  = !r_out_valid || out_ready;
  assign w_fire    = in_valid && in_ready;

  // IDLE implies a clean frame start regardless of leftover registers
  assign w_bin     = (r_state == MID) ? r_borrow : 1'b0;
  assign w_cnt_cur = (r_state == MID) ? r_cnt : '0;
  assign w_cnt_nx  = w_cnt_cur + CW'(1);
  assign w_max     = (w_cnt_nx == MAXC);
  assign w_final   = in_last || w_max;
  assign w_ovf     = w_max && !in_last;

  assign w_bad = (a_dig > 3'd4) || (b_dig > 3'd4);
  assign w_t   = $signed({2'b00, a_dig})
               - $signed({2'b00, b_dig})
               - $signed({4'b0000, w_bin});
  assign w_tp5 = w_t + 5'sd5;

  // Digit arithmetic; invalid digits yield zero with no borrow
  always_comb begin
    w_diff = w_t[2:0];
    w_nb   = 1'b0;
    if (w_bad) begin
      w_diff = 3'd0;
      w_nb   = 1'b0;
    end else if (w_t < 0) begin
      w_diff = w_tp5[2:0];
      w_nb   = 1'b1;
    end
  end

  assign w_err = r_err || w_bad || w_ovf;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nx;
  end

  // FSM next state: the final digit always closes the frame
  always_comb begin
    w_state_nx = r_state;
    if (w_fire) begin
      if (w_final) w_state_nx = IDLE;
      else         w_state_nx = MID;
    end
  end

  // Frame context: borrow, digit count, sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_borrow <= 1'b0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
    end else if (w_fire) begin
      if (w_final) begin
        r_borrow <= 1'b0;
        r_cnt    <= '0;
        r_err    <= 1'b0;
      end else begin
        r_borrow <= w_nb;
        r_cnt    <= w_cnt_nx;
        r_err    <= w_err;
      end
    end
  end

  // Output register: load on accept, drop valid on bare drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_diff      <= 3'd0;
      r_last      <= 1'b0;
      r_bout      <= 1'b0;
      r_oerr      <= 1'b0;
    end else if (w_fire) begin
      r_out_valid <= 1'b1;
      r_diff      <= w_diff;
      r_last      <= w_final;
      r_bout      <= w_final && w_nb;
      r_oerr      <= w_err;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign diff_dig  = r_diff;
  assign out_last  = r_last;
  assign out_bout  = r_bout;
  assign out_err   = r_oerr;

endmodule

// File: tb/tb_penta_serial_sub.sv
// Directed vector bench for penta_serial_sub (MAX_DIGITS=4).
// Table of digit pairs plus backpressure and mid-frame reset sequences.
module tb_penta_serial_sub;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] a_dig;
  logic [2:0] b_dig;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] diff_dig;
  logic       out_last;
  logic       out_bout;
  logic       out_err;

  int n_vec;
  int n_bad;

  typedef struct packed {
    logic [2:0] a;
    logic [2:0] b;
    logic       last;
    logic [2:0] d;
    logic       l;
    logic       bo;
    logic       e;
  } vec_t;

  localparam int NV = 20;
  vec_t tv [NV];

  penta_serial_sub #(.MAX_DIGITS(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_dig    (a_dig),
    .b_dig    (b_dig),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .diff_dig (diff_dig),
    .out_last (out_last),
    .out_bout (out_bout),
    .out_err  (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // packed view {valid, diff[2:0], last, bout, err}
  function automatic logic [6:0] obs();
    return {out_valid, diff_dig, out_last, out_bout, out_err};
  endfunction

  task automatic chk(input string nm, input logic [6:0] got,
                     input logic [6:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got v/d/l/b/e=%b expected %b", nm, got, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic got, input logic exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", nm, got, exp);
    end
  endtask

  task automatic drive(input logic [2:0] a, input logic [2:0] b,
                       input logic l);
    in_valid = 1'b1;
    a_dig    = a;
    b_dig    = b;
    in_last  = l;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    //           a     b     last  diff  l     bo    e
    tv[0]  = '{3'd4, 3'd1, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0};
    tv[1]  = '{3'd3, 3'd4, 1'b0, 3'd4, 1'b0, 1'b0, 1'b0};
    tv[2]  = '{3'd1, 3'd0, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0};
    tv[3]  = '{3'd1, 3'd3, 1'b1, 3'd3, 1'b1, 1'b1, 1'b0};
    tv[4]  = '{3'd6, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1};
    tv[5]  = '{3'd3, 3'd1, 1'b0, 3'd2, 1'b0, 1'b0, 1'b1};
    tv[6]  = '{3'd2, 3'd4, 1'b1, 3'd3, 1'b1, 1'b1, 1'b1};
    tv[7]  = '{3'd2, 3'd2, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0};
    tv[8]  = '{3'd1, 3'd7, 1'b1, 3'd0, 1'b1, 1'b0, 1'b1};
    tv[9]  = '{3'd0, 3'd0, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0};
    tv[10] = '{3'd0, 3'd1, 1'b0, 3'd4, 1'b0, 1'b0, 1'b0};
    tv[11] = '{3'd1, 3'd1, 1'b0, 3'd4, 1'b0, 1'b0, 1'b0};
    tv[12] = '{3'd4, 3'd0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0};
    tv[13] = '{3'd2, 3'd3, 1'b0, 3'd4, 1'b1, 1'b1, 1'b1};
    tv[14] = '{3'd1, 3'd0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0};
    tv[15] = '{3'd1, 3'd0, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0};
    tv[16] = '{3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0};
    tv[17] = '{3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0};
    tv[18] = '{3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0};
    tv[19] = '{3'd0, 3'd0, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a_dig     = 3'd0;
    b_dig     = 3'd0;
    in_last   = 1'b0;
    out_ready = 1'b1;

    #2;
    chk("reset_out", obs(), 7'b0);
    chk1("reset_in_ready", in_ready, 1'b1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk1("post_reset_in_ready", in_ready, 1'b1);

    // streaming table with out_ready held high
    for (int i = 0; i < NV; i++) begin
      drive(tv[i].a, tv[i].b, tv[i].last);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d", i), obs(),
          {1'b1, tv[i].d, tv[i].l, tv[i].bo, tv[i].e});
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk1("drain_valid", out_valid, 1'b0);

    // backpressure: result pending for 3 cycles, next digit waiting
    out_ready = 1'b0;
    drive(3'd1, 3'd0, 1'b0);
    @(posedge clk);
    #1;
    chk("bp_load", obs(), {1'b1, 3'd1, 1'b0, 1'b0, 1'b0});
    drive(3'd2, 3'd0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk1($sformatf("bp_in_ready%0d", k), in_ready, 1'b0);
      @(posedge clk);
      #1;
      chk($sformatf("bp_hold%0d", k), obs(),
          {1'b1, 3'd1, 1'b0, 1'b0, 1'b0});
    end
    out_ready = 1'b1;
    #1;
    chk1("bp_release_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    chk("bp_next", obs(), {1'b1, 3'd2, 1'b1, 1'b0, 1'b0});
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk1("bp_empty", out_valid, 1'b0);

    // mid-frame reset clears outputs immediately and drops the borrow
    drive(3'd1, 3'd2, 1'b0);
    @(posedge clk);
    #1;
    chk("mr_load", obs(), {1'b1, 3'd4, 1'b0, 1'b0, 1'b0});
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mr_async", obs(), 7'b0);
    chk1("mr_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive(3'd3, 3'd1, 1'b1);
    @(posedge clk);
    #1;
    chk("mr_fresh", obs(), {1'b1, 3'd2, 1'b1, 1'b0, 1'b0});
    in_valid = 1'b0;
    @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
